store_lane_packer: RTL and testbench

- Store-side counterpart of the load-path zero/sign extenders.
- Narrows a 32-bit register value to byte, half or word width and places it on the correct byte lanes of the 32-bit data-memory write bus.
- Produces a word-aligned address and a byte-enable mask.
- Sits between the execute stage and data memory, with valid/ready handshakes on both sides and a one-entry output register.

---
 rtl/store_lane_packer_if.sv | 28 ++
 rtl/store_lane_packer.sv | 149 ++++++++++++++
 tb/tb_store_lane_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_lane_packer_if.sv
// Handshake bundle between the execute stage, the store lane packer and data memory.
// The slave modport is the packer's view; the master modport is the view of its surroundings.
interface store_lane_packer_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_wdata;
  logic [3:0]        out_be;
  logic              out_err;

  modport slave (
    input  in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_wdata, out_be, out_err
  );

  modport master (
    output in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_wdata, out_be, out_err
  );
endinterface

// File: rtl/store_lane_packer.sv
// Store lane packer: narrows a register value onto byte lanes of the data-memory write bus.
// Define STORE_MISALIGN_SPLIT_EN to split misaligned half/word stores into two beats.
module store_lane_packer #(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  store_lane_packer_if.slave   bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic              load;
  logic              accept;
  logic [1:0]        lane_off;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       sized_data;
  logic [3:0]        size_mask;
  logic              illegal;
  logic              misaligned;
  logic              beat_err;
  logic [3:0]        beat_be;
  logic [31:0]       beat_wdata;

  assign lane_off     = bus.in_addr[1:0];
  assign aligned_addr = {bus.in_addr[ADDR_W-1:2], 2'b00};
  assign load         = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Zero-extend to the access size; an illegal size leaves data and mask empty.
  always_comb begin
    sized_data = 32'h0;
    size_mask  = 4'b0000;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (bus.in_size)
      2'b00: begin
        sized_data = {24'h0, bus.in_data[7:0]};
        size_mask  = 4'b0001;
      end
      2'b01: begin
        sized_data = {16'h0, bus.in_data[15:0]};
        size_mask  = 4'b0011;
        misaligned = (lane_off == 2'd3);
      end
      2'b10: begin
        sized_data = bus.in_data;
        size_mask  = 4'b1111;
        misaligned = (lane_off != 2'd0);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

`ifdef STORE_MISALIGN_SPLIT_EN
  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [63:0]       spread_data;
  logic [7:0]        spread_mask;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       pend_wdata;
  logic [3:0]        pend_be;

  // The upper half of the spread holds whatever spills into the next word.
  assign spread_data = {32'h0, sized_data} << {lane_off, 3'b000};
  assign spread_mask = {4'h0, size_mask} << lane_off;

  assign beat_err    = illegal;
  assign beat_be     = spread_mask[3:0];
  assign beat_wdata  = spread_data[31:0];
  assign bus.in_ready = load && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && misaligned) state_nxt = SECOND;
      SECOND:  if (load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_addr  <= aligned_addr + ADDR_W'(4);
      pend_wdata <= spread_data[63:32];
      pend_be    <= spread_mask[7:4];
    end
  end
`else
  assign beat_err    = illegal || misaligned;
  assign beat_be     = beat_err ? 4'h0 : (size_mask << lane_off);
  assign beat_wdata  = beat_err ? 32'h0 : (sized_data << {lane_off, 3'b000});
  assign bus.in_ready = load;
`endif

  // One-entry output register; it only changes when empty or being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_wdata <= 32'h0;
      bus.out_be    <= 4'h0;
      bus.out_err   <= 1'b0;
    end else if (load) begin
`ifdef STORE_MISALIGN_SPLIT_EN
      if (state == SECOND) begin
        bus.out_valid <= 1'b1;
        bus.out_addr  <= pend_addr;
        bus.out_wdata <= pend_wdata;
        bus.out_be    <= pend_be;
        bus.out_err   <= 1'b0;
      end else
`endif
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_addr  <= aligned_addr;
        bus.out_wdata <= beat_wdata;
        bus.out_be    <= beat_be;
        bus.out_err   <= beat_err;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_store_lane_packer.sv
// Testbench for store_lane_packer: directed scenarios plus randomized traffic
// checked against a byte-lane reference model and expected-beat queue.
module tb_store_lane_packer;
  localparam int ADDR_W    = 32;
  localparam int ERR_CNT_W = 2;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ERR_CNT_W-1:0] err_count;
  int                   vectors = 0;
  int                   miscompares = 0;

  store_lane_packer_if #(.ADDR_W(ADDR_W)) bus ();

  store_lane_packer #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    model_errs;

  // Expected beats from a request, built one byte lane at a time.
  function automatic void model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    beat_t b0, b1;
    int    o, nb;
    o = int'(a[1:0]);
    b0.addr = {a[31:2], 2'b00};
    b0.wdata = 32'h0;
    b0.be = 4'h0;
    b0.err = 1'b0;
    b1 = b0;
    b1.addr = b0.addr + 32'd4;
    if (sz == 2'b11) begin
      b0.err = 1'b1;
      exp_q.push_back(b0);
      return;
    end
    nb = 1 << sz;
    if ((o + nb > 4) && !SPLIT) begin
      b0.err = 1'b1;
      exp_q.push_back(b0);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      int lane;
      logic [7:0] bv;
      lane = o + k;
      bv = d[8*k +: 8];
      if (lane < 4) begin
        b0.be[lane] = 1'b1;
        b0.wdata[8*lane +: 8] = bv;
      end else begin
        b1.be[lane-4] = 1'b1;
        b1.wdata[8*(lane-4) +: 8] = bv;
      end
    end
    exp_q.push_back(b0);
    if (o + nb > 4) exp_q.push_back(b1);
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_addr   = 32'h0;
    bus.in_data   = 32'h0;
    bus.in_size   = 2'b00;
    bus.out_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_size  = sz;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    vectors++;
    if ({bus.out_valid, bus.out_addr, bus.out_wdata, bus.out_be, bus.out_err, err_count, bus.in_ready}
        !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%0b a=%h d=%h be=%b e=%0b cnt=%0d rdy=%0b want 0 0 0 0000 0 0 1",
               bus.out_valid, bus.out_addr, bus.out_wdata, bus.out_be, bus.out_err, err_count, bus.in_ready);
    end
  endtask

  task automatic test_byte();
    reset_dut();
    drive_req(32'h1002, 32'hDEADBEEF, 2'b00);
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err}
        !== {1'b1, 32'h1000, 4'b0100, 32'h00EF0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL byte_beat: got v=%0b a=%h be=%b d=%h e=%0b want 1 00001000 0100 00ef0000 0",
               bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL byte_drain: got out_valid=%0b want 0", bus.out_valid);
    end
  endtask

  task automatic test_half_backpressure();
    reset_dut();
    bus.out_ready = 1'b0;
    drive_req(32'h2002, 32'h1234ABCD, 2'b01);
    step();
    drive_req(32'h2005, 32'h00000077, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.in_ready}
          !== {1'b1, 32'h2000, 4'b1100, 32'hABCD0000, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL half_hold[%0d]: got v=%0b a=%h be=%b d=%h rdy=%0b want 1 00002000 1100 abcd0000 0",
                 i, bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL half_release_ready: got in_ready=%0b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err}
        !== {1'b1, 32'h2004, 4'b0010, 32'h00007700, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL overlap_beat: got v=%0b a=%h be=%b d=%h e=%0b want 1 00002004 0010 00007700 0",
               bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      drive_req(32'(4 * k), d, 2'b10);
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready[%0d]: got in_ready=%0b want 1", k, bus.in_ready);
      end
      step();
      vectors++;
      if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err}
          !== {1'b1, 32'(4 * k), 4'b1111, d, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL b2b_beat[%0d]: got v=%0b a=%h be=%b d=%h e=%0b want 1 %h 1111 %h 0",
                 k, bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err, 32'(4 * k), d);
      end
    end
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain: got out_valid=%0b want 0", bus.out_valid);
    end
  endtask

  task automatic test_misaligned();
    reset_dut();
    drive_req(32'h3001, 32'hAABBCCDD, 2'b10);
    step();
    bus.in_valid = 1'b0;
    if (SPLIT) begin
      vectors++;
      if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err, bus.in_ready}
          !== {1'b1, 32'h3000, 4'b1110, 32'hBBCCDD00, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL split_beat1: got v=%0b a=%h be=%b d=%h e=%0b rdy=%0b want 1 00003000 1110 bbccdd00 0 0",
                 bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err, bus.in_ready);
      end
      step();
      vectors++;
      if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err}
          !== {1'b1, 32'h3004, 4'b0001, 32'h000000AA, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL split_beat2: got v=%0b a=%h be=%b d=%h e=%0b want 1 00003004 0001 000000aa 0",
                 bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err);
      end
      step();
      vectors++;
      if ({bus.out_valid, err_count} !== {1'b0, 2'd0}) begin
        miscompares++;
        $display("[TB] FAIL split_done: got v=%0b cnt=%0d want 0 0", bus.out_valid, err_count);
      end
    end else begin
      vectors++;
      if ({bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err}
          !== {1'b1, 32'h3000, 4'b0000, 32'h0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL misalign_err: got v=%0b a=%h be=%b d=%h e=%0b want 1 00003000 0000 00000000 1",
                 bus.out_valid, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err);
      end
      step();
      vectors++;
      if ({bus.out_valid, err_count} !== {1'b0, 2'd1}) begin
        miscompares++;
        $display("[TB] FAIL misalign_count: got v=%0b cnt=%0d want 0 1", bus.out_valid, err_count);
      end
    end
  endtask

  task automatic test_err_saturation();
    int exp_cnt;
    reset_dut();
    for (int j = 1; j <= 5; j++) begin
      drive_req($urandom, $urandom, 2'b11);
      step();
      exp_cnt = (j - 1 > 3) ? 3 : j - 1;
      vectors++;
      if ({bus.out_valid, bus.out_err, bus.out_be, bus.out_wdata, err_count}
          !== {1'b1, 1'b1, 4'h0, 32'h0, 2'(exp_cnt)}) begin
        miscompares++;
        $display("[TB] FAIL sat_beat[%0d]: got v=%0b e=%0b be=%b d=%h cnt=%0d want 1 1 0000 00000000 %0d",
                 j, bus.out_valid, bus.out_err, bus.out_be, bus.out_wdata, err_count, exp_cnt);
      end
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step();
      vectors++;
      if (err_count !== 2'd3) begin
        miscompares++;
        $display("[TB] FAIL sat_hold[%0d]: got err_count=%0d want 3", j, err_count);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    drive_req(32'h0100, 32'h55AA55AA, 2'b10);
    step();
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_pending: got out_valid=%0b want 1", bus.out_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.out_be, err_count, bus.in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got v=%0b be=%b cnt=%0d rdy=%0b want 0 0000 0 1",
               bus.out_valid, bus.out_be, err_count, bus.in_ready);
    end
  endtask

  task automatic test_random();
    beat_t h;
    bit    exp_valid, exp_ready;
    reset_dut();
    exp_q.delete();
    model_errs = 0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_addr   = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      bus.in_data   = $urandom;
      bus.in_size   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_valid = (exp_q.size() > 0);
      exp_ready = (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1);
      vectors++;
      if ({bus.out_valid, bus.in_ready, err_count} !== {exp_valid, exp_ready, 2'(model_errs)}) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl[%0d]: got v=%0b rdy=%0b cnt=%0d want %0b %0b %0d",
                 c, bus.out_valid, bus.in_ready, err_count, exp_valid, exp_ready, model_errs);
      end
      if (exp_valid) begin
        h = exp_q[0];
        vectors++;
        if ({bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err} !== {h.addr, h.be, h.wdata, h.err}) begin
          miscompares++;
          $display("[TB] FAIL rand_beat[%0d]: got a=%h be=%b d=%h e=%0b want %h %b %h %0b",
                   c, bus.out_addr, bus.out_be, bus.out_wdata, bus.out_err, h.addr, h.be, h.wdata, h.err);
        end
        if (bus.out_ready) begin
          h = exp_q.pop_front();
          if (h.err && model_errs < (1 << ERR_CNT_W) - 1) model_errs++;
        end
      end
      if (bus.in_valid && exp_ready) model_push(bus.in_addr, bus.in_data, bus.in_size);
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_byte();
    test_half_backpressure();
    test_back_to_back();
    test_misaligned();
    test_err_saturation();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
